// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared pipeline-control bit positions, widths and the MEM stage state type.
package mips_pipe_pkg;
    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 32;
    localparam int REG_W_DEF   = 5;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;
    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register; a bubble clears writeback control and holds the data fields.
module mem_wb_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              bubble_i,
    input  logic              ld_rdata_i,
    input  logic [1:0]        wb_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [REG_W-1:0]  rd_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [1:0]        wb_o,
    output logic [DATA_W-1:0] alu_o,
    output logic [REG_W-1:0]  rd_o,
    output logic [DATA_W-1:0] rdata_o
);
    logic [1:0]        wb_q;
    logic [DATA_W-1:0] alu_q, rdata_q;
    logic [REG_W-1:0]  rd_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb_q    <= '0;
            alu_q   <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
        end else begin
            wb_q <= bubble_i ? 2'b00 : wb_i;
            if (!bubble_i) begin
                alu_q <= alu_i;
                rd_q  <= rd_i;
            end
            if (ld_rdata_i) rdata_q <= rdata_i;
        end
    end

    assign wb_o    = wb_q;
    assign alu_o   = alu_q;
    assign rd_o    = rd_q;
    assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage issuing data-memory loads/stores over req/ack and stalling upstream meanwhile.
// Define MEMSTAGE_ALIGN_CHECK_EN to squash word-misaligned accesses and pulse align_err instead.
module mem_access_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        WB,
    input  logic [1:0]        M,
    input  logic [DATA_W-1:0] ALUIn,
    input  logic [DATA_W-1:0] WriteDataIn,
    input  logic [REG_W-1:0]  RegRDIn,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic [1:0]        WBreg,
    output logic [DATA_W-1:0] ReadDataOut,
    output logic [DATA_W-1:0] ALUreg,
    output logic [REG_W-1:0]  RegRDreg,
    output logic              align_err
);
    state_t            state_q, state_d;
    logic              req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, cap_alu_q, cap_alu_d;
    logic [1:0]        cap_wb_q, cap_wb_d;
    logic [REG_W-1:0]  cap_rd_q, cap_rd_d;
    logic              access, misalign, issue, done, waiting;

    assign access = M[M_MEMREAD] | M[M_MEMWRITE];
`ifdef MEMSTAGE_ALIGN_CHECK_EN
    assign misalign = ALUIn[1:0] != 2'b00;
`else
    assign misalign = 1'b0;
`endif
    assign issue   = state_q == IDLE && access && !misalign;
    assign done    = state_q == BUSY && mem_ack;
    assign waiting = state_q == BUSY && !mem_ack;
    // The ack cycle releases the stall so EX/MEM advances on the completing edge.
    assign stall   = issue || waiting;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cap_wb_d  = cap_wb_q;
        cap_alu_d = cap_alu_q;
        cap_rd_d  = cap_rd_q;
        if (issue) begin
            state_d   = BUSY;
            req_d     = 1'b1;
            we_d      = M[M_MEMWRITE];
            addr_d    = ALUIn[ADDR_W-1:0];
            wdata_d   = WriteDataIn;
            cap_wb_d  = WB;
            cap_alu_d = ALUIn;
            cap_rd_d  = RegRDIn;
        end else if (done) begin
            state_d = IDLE;
            req_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cap_wb_q  <= '0;
            cap_alu_q <= '0;
            cap_rd_q  <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cap_wb_q  <= cap_wb_d;
            cap_alu_q <= cap_alu_d;
            cap_rd_q  <= cap_rd_d;
        end
    end

`ifdef MEMSTAGE_ALIGN_CHECK_EN
    logic align_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) align_q <= 1'b0;
        else          align_q <= state_q == IDLE && access && misalign;
    end
    assign align_err = align_q;
`else
    assign align_err = 1'b0;
`endif

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Every IDLE access cycle (issued or squashed) and every wait cycle emits a bubble.
    mem_wb_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_mem_wb (
        .clk_i      (clock),
        .rst_n_i    (reset_n),
        .bubble_i   ((state_q == IDLE && access) || waiting),
        .ld_rdata_i (done && !we_q),
        .wb_i       (state_q == BUSY ? cap_wb_q : WB),
        .alu_i      (state_q == BUSY ? cap_alu_q : ALUIn),
        .rd_i       (state_q == BUSY ? cap_rd_q : RegRDIn),
        .rdata_i    (mem_rdata),
        .wb_o       (WBreg),
        .alu_o      (ALUreg),
        .rd_o       (RegRDreg),
        .rdata_o    (ReadDataOut)
    );
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for mem_access_stage with a randomized-latency memory responder.
module tb_mem_access_stage;
    logic        clock = 1'b0, reset_n = 1'b0;
    logic [1:0]  WB = '0, M = '0;
    logic [31:0] ALUIn = '0, WriteDataIn = '0, mem_rdata = '0;
    logic [4:0]  RegRDIn = '0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, stall, align_err;
    logic [31:0] mem_addr, mem_wdata, ReadDataOut, ALUreg;
    logic [1:0]  WBreg;
    logic [4:0]  RegRDreg;

    mem_access_stage dut (
        .clock(clock), .reset_n(reset_n), .WB(WB), .M(M), .ALUIn(ALUIn),
        .WriteDataIn(WriteDataIn), .RegRDIn(RegRDIn), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .WBreg(WBreg), .ReadDataOut(ReadDataOut), .ALUreg(ALUreg),
        .RegRDreg(RegRDreg), .align_err(align_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {logic [1:0] wb; logic [31:0] alu; logic [4:0] rd; logic [31:0] rdata;} wb_t;
    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} req_t;
    wb_t  exp_q[$];
    req_t req_q[$];
    int   dly_q[$];
    int   n_cmp = 0, n_err = 0, stray_req = 0, stray_done = 0;
    logic [31:0] last_rd = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Memory model: answers each request after the delay chosen by the issuer.
    int   cnt = 0;
    bit   have = 0, acked = 0;
    req_t r;
    always @(negedge clock) begin
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        if (stray_req != stray_done) begin
            mem_ack = 1'b1;
            stray_done++;
        end else if (!mem_req) begin
            have = 0;
            acked = 0;
        end else if (acked) chk("req_gap", mem_req, 0);
        else begin
            if (!have) begin
                have = 1;
                cnt = dly_q.size() != 0 ? dly_q.pop_front() : 0;
            end
            if (cnt == 0) begin
                mem_ack = 1'b1;
                acked = 1;
                mem_rdata = memf(mem_addr);
                if (req_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL req_extra: request addr %h with none expected", mem_addr);
                end else begin
                    r = req_q.pop_front();
                    chk("mem_we", mem_we, r.we);
                    chk("mem_addr", mem_addr, r.addr);
                    chk("mem_wdata", mem_wdata, r.wdata);
                end
            end else cnt--;
        end
    end

    wb_t e;
    always @(negedge clock) begin
        if (reset_n && WBreg != 2'b00) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL wb_extra: WBreg %b with no instruction pending", WBreg);
            end else begin
                e = exp_q.pop_front();
                chk("WBreg", WBreg, e.wb);
                chk("ALUreg", ALUreg, e.alu);
                chk("RegRDreg", RegRDreg, e.rd);
                chk("ReadDataOut", ReadDataOut, e.rdata);
            end
        end
    end

    task automatic issue(input logic [1:0] wb, input logic [1:0] m, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rd, input int d);
        bit   acc, sq;
        int   n;
        req_t q;
        n = 0;
        acc = m != 2'b00;
`ifdef MEMSTAGE_ALIGN_CHECK_EN
        sq = acc && alu[1:0] != 2'b00;
`else
        sq = 0;
`endif
        @(negedge clock);
        WB = wb; M = m; ALUIn = alu; WriteDataIn = wd; RegRDIn = rd;
        if (acc && !sq) begin
            dly_q.push_back(d);
            q = '{we: m[0], addr: alu, wdata: wd};
            req_q.push_back(q);
            if (!m[0]) last_rd = memf(alu);
        end
        if (!sq) exp_q.push_back('{wb: wb, alu: alu, rd: rd, rdata: last_rd});
        forever begin
            #4;
            if (!stall || n > 40) break;
            n++;
            @(negedge clock);
        end
        chk("stall_cycles", n, (acc && !sq) ? 1 + d : 0);
        @(posedge clock);
        #1;
        chk("align_err", align_err, sq);
        chk("mem_req_after", mem_req, 0);
    endtask

    task automatic idle();
        @(negedge clock);
        WB = 2'b00;
        M = 2'b00;
    endtask

    logic [1:0]  rm;
    logic [31:0] ra;
    initial begin
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            WB = 2'($urandom); M = 2'($urandom); ALUIn = $urandom; WriteDataIn = $urandom; RegRDIn = 5'($urandom);
        end
        chk("rst_WBreg", WBreg, 0);
        chk("rst_ALUreg", ALUreg, 0);
        chk("rst_RegRDreg", RegRDreg, 0);
        chk("rst_ReadDataOut", ReadDataOut, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_align_err", align_err, 0);
        WB = 2'b00; M = 2'b00;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1 chk("req_after_reset", mem_req, 0);

        issue(2'b10, 2'b00, 32'h10, 32'h0, 5'd5, 0);
        issue(2'b11, 2'b10, 32'h100, 32'h0BAD_0BAD, 5'd7, 3);
        issue(2'b10, 2'b01, 32'h200, 32'h1234_5678, 5'd9, 0);
        issue(2'b11, 2'b10, 32'h104, 32'h0, 5'd3, 1);
        issue(2'b01, 2'b11, 32'h108, 32'hCAFE_F00D, 5'd4, 2);
        issue(2'b11, 2'b10, 32'h102, 32'h0, 5'd8, 1);
        idle();

        @(negedge clock);
        WB = 2'b11; M = 2'b10; ALUIn = 32'h300; RegRDIn = 5'd1;
        dly_q.push_back(20);
        @(posedge clock);
        #1 chk("rst_mid_issue", mem_req, 1);
        @(negedge clock);
        WB = 2'b00; M = 2'b00;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_req_drop", mem_req, 0);
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_WBreg", WBreg, 0);
        last_rd = '0;
        @(negedge clock);
        #1 reset_n = 1'b1;
        stray_req++;
        issue(2'b10, 2'b00, 32'h44, 32'h0, 5'd6, 0);

        repeat (300) begin
            rm = $urandom_range(0, 2) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            issue(2'($urandom_range(1, 3)), rm, ra, $urandom, 5'($urandom), $urandom_range(0, 3));
        end
        idle();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
        chk("wb_pending", exp_q.size(), 0);
        chk("req_pending", req_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
